// File: rtl/addsub_acc_if.sv
// addsub_acc_if -- operand/result bus for the add/subtract accumulator.
//
// Signals:
//   in_valid  : operand beat offered (master -> slave)
//   in_ready  : accumulator accepts a beat (slave -> master)
//   in_data   : 4-bit unsigned operand
//   in_op     : 0 = add, 1 = subtract
//   in_last   : final beat of the current sequence
//   out_valid : result registers valid (slave -> master)
//   out_ready : downstream takes the result (master -> slave)
//   out_acc   : accumulated result
//   out_flag  : sticky carry/borrow seen in this sequence
//   out_cnt   : beats accepted in this sequence, saturating at 31
//
// Modports:
//   master : the side that feeds operands and consumes results
//   slave  : the accumulator itself
interface addsub_acc_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_op;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_acc;
  logic       out_flag;
  logic [4:0] out_cnt;

  modport master (
    output in_valid, in_data, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_flag, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_op, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_flag, out_cnt
  );
endinterface

// File: rtl/addsub_acc.sv
// addsub_acc -- 4-bit add/subtract accumulator with a sticky carry/borrow
// flag and a saturating beat counter.
//
// The block collects a sequence of operand beats, each one adding to or
// subtracting from the running accumulator. The beat flagged in_last closes
// the sequence: the result is then presented on out_* until downstream
// takes it, after which acc/flag/cnt clear and a new sequence may start.
//
// Ports:
//   clk : rising-edge clock for all state
//   rst : synchronous active-high reset
//   bus : addsub_acc_if.slave (operand beats in, result out)
//
// Configuration:
//   ADDSUB_ACC_SAT_EN -- when defined, add overflow clamps acc to 15 and
//   subtract underflow clamps acc to 0 instead of wrapping modulo 16. The
//   sticky flag is set identically in both builds.
module addsub_acc (
  input  logic       clk,
  input  logic       rst,
  addsub_acc_if.slave bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_q,   acc_d;
  logic       flag_q,  flag_d;
  logic [4:0] cnt_q,   cnt_d;

  logic       beat_s;
  logic       take_s;
  logic [4:0] step_s;

  // One arithmetic beat. Returns {carry_or_borrow, new_acc}.
  function automatic logic [4:0] acc_step(
    input logic [3:0] acc,
    input logic       op,
    input logic [3:0] data
  );
    logic [4:0] sum;
    logic [3:0] diff;
    logic       borrow;
    logic [4:0] res;
    sum    = {1'b0, acc} + {1'b0, data};
    diff   = acc - data;
    borrow = (data > acc);
    if (op == 1'b0) begin
`ifdef ADDSUB_ACC_SAT_EN
      res = {sum[4], (sum[4] ? 4'd15 : sum[3:0])};
`else
      res = sum;  // carry in bit 4, wrapped value in bits 3:0
`endif
    end else begin
`ifdef ADDSUB_ACC_SAT_EN
      res = {borrow, (borrow ? 4'd0 : diff)};
`else
      res = {borrow, diff};
`endif
    end
    return res;
  endfunction

  // Handshake qualifiers; in_ready comes from state only, so no path from in_valid.
  always_comb begin
    beat_s = bus.in_valid & (state_q == ST_ACCUM);
    take_s = bus.out_ready & (state_q == ST_DONE);
    step_s = acc_step(acc_q, bus.in_op, bus.in_data);
  end

  // Next-state and next-datapath logic; defaults hold everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat_s) begin
          acc_d  = step_s[3:0];
          flag_d = flag_q | step_s[4];
          cnt_d  = (cnt_q == 5'd31) ? cnt_q : (cnt_q + 5'd1);
          if (bus.in_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (take_s) begin
          state_d = ST_ACCUM;
          acc_d   = 4'd0;
          flag_d  = 1'b0;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        acc_d   = 4'd0;
        flag_d  = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any beat or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= 4'd0;
      flag_q  <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are taken straight from registers.
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_flag  = flag_q;
  assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_addsub_acc.sv
// tb_addsub_acc -- self-checking bench for addsub_acc.
// Directed two-beat vectors from a table, hand-written corner sequences and
// randomized traffic, all compared against a behavioural model.
// Honours ADDSUB_ACC_SAT_EN in its expectations.
module tb_addsub_acc;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Behavioural model of the observable state
  int   m_acc;
  int   m_flag;
  int   m_cnt;
  int   m_done;

  addsub_acc_if bus ();

  addsub_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op0;
    logic [3:0] d0;
    logic       op1;
    logic [3:0] d1;
    int         exp_acc;
    int         exp_flag;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model of one clock edge, from the block's rules in plain arithmetic.
  task automatic model_edge(input logic r, input logic v, input logic op,
                            input logic [3:0] d, input logic last,
                            input logic ordy);
    int s;
    if (r) begin
      m_acc = 0; m_flag = 0; m_cnt = 0; m_done = 0;
    end else if (m_done == 0) begin
      if (v) begin
        if (op == 1'b0) begin
          s = m_acc + int'(d);
          if (s > 15) m_flag = 1;
`ifdef ADDSUB_ACC_SAT_EN
          m_acc = (s > 15) ? 15 : s;
`else
          m_acc = s % 16;
`endif
        end else begin
          s = m_acc - int'(d);
          if (s < 0) m_flag = 1;
`ifdef ADDSUB_ACC_SAT_EN
          m_acc = (s < 0) ? 0 : s;
`else
          m_acc = (s + 16) % 16;
`endif
        end
        m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
        if (last) m_done = 1;
      end
    end else if (ordy) begin
      m_acc = 0; m_flag = 0; m_cnt = 0; m_done = 0;
    end
  endtask

  // Apply inputs for one cycle (called at a negedge), then compare at the next negedge.
  task automatic cycle(input logic r, input logic v, input logic op,
                       input logic [3:0] d, input logic last, input logic ordy);
    rst           = r;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = ordy;
    model_edge(r, v, op, d, last, ordy);
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    chk("in_ready",  int'(bus.in_ready),  (m_done == 0) ? 1 : 0);
    chk("out_valid", int'(bus.out_valid), m_done);
    chk("out_acc",   int'(bus.out_acc),   m_acc);
    chk("out_flag",  int'(bus.out_flag),  m_flag);
    chk("out_cnt",   int'(bus.out_cnt),   m_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_acc = 0; m_flag = 0; m_cnt = 0; m_done = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_data = 4'd0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);

    // Directed two-beat vectors (second beat is last)
    vecs[0] = '{1'b0, 4'd3,  1'b0, 4'd5, 8,  0};
`ifdef ADDSUB_ACC_SAT_EN
    vecs[1] = '{1'b0, 4'd12, 1'b0, 4'd7, 15, 1};
    vecs[2] = '{1'b0, 4'd2,  1'b1, 4'd5, 0,  1};
    vecs[3] = '{1'b0, 4'd15, 1'b0, 4'd15, 15, 1};
    vecs[5] = '{1'b1, 4'd1,  1'b0, 4'd3, 3,  1};
`else
    vecs[1] = '{1'b0, 4'd12, 1'b0, 4'd7, 3,  1};
    vecs[2] = '{1'b0, 4'd2,  1'b1, 4'd5, 13, 1};
    vecs[3] = '{1'b0, 4'd15, 1'b0, 4'd15, 14, 1};
    vecs[5] = '{1'b1, 4'd1,  1'b0, 4'd3, 2,  1};
`endif
    vecs[4] = '{1'b0, 4'd9,  1'b1, 4'd4, 5,  0};

    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, vecs[i].op0, vecs[i].d0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, vecs[i].op1, vecs[i].d1, 1'b1, 1'b0);
      chk("vec_out_valid", int'(bus.out_valid), 1);
      chk("vec_out_acc",   int'(bus.out_acc),   vecs[i].exp_acc);
      chk("vec_out_flag",  int'(bus.out_flag),  vecs[i].exp_flag);
      chk("vec_out_cnt",   int'(bus.out_cnt),   2);
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("vec_back_accum", int'(bus.in_ready), 1);
      chk("vec_cleared_acc", int'(bus.out_acc), 0);
    end

    // DONE holds while out_ready is low and in_valid is offered
    cycle(1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
      chk("hold_acc", int'(bus.out_acc), 6);
      chk("hold_cnt", int'(bus.out_cnt), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("hold_release_cnt", int'(bus.out_cnt), 0);

    // Reset discards a partial sequence
    cycle(1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    chk("rst_mid_acc", int'(bus.out_acc), 0);
    chk("rst_mid_cnt", int'(bus.out_cnt), 0);
    cycle(1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    chk("after_rst_acc", int'(bus.out_acc), 1);
    chk("after_rst_cnt", int'(bus.out_cnt), 1);
    // Reset overrides an output handshake too
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("rst_done_valid", int'(bus.out_valid), 0);

    // in_last without in_valid does nothing
    cycle(1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    chk("last_no_valid", int'(bus.out_valid), 0);

    // Counter saturation: 40 beats of +0
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'd0, (i == 39) ? 1'b1 : 1'b0, 1'b0);
    end
    chk("sat_cnt", int'(bus.out_cnt), 31);
    chk("sat_acc", int'(bus.out_acc), 0);
    chk("sat_flag", int'(bus.out_flag), 0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
